uart_tx_serializer: RTL and testbench
=====================================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter CLK_DIV_WIDTH, default 16, is the width of the bit-period divider input.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 s_data  input  8  byte to transmit.
REQ-005 s_valid  input  1  s_data valid.
REQ-006 s_ready  output  1  block can accept a byte this cycle.
REQ-007 cfg_parity_en  input  1  1 = append a parity bit.
REQ-008 cfg_parity_type  input  1  0 = even parity, 1 = odd parity.
REQ-009 cfg_num_stop_bits  input  2  stop-bit count; 0 or 1 means 1 bit, 2 or 3 means 2 bits.
REQ-010 cfg_clk_div  input  CLK_DIV_WIDTH  clocks per bit period; 0 is treated as 1.
REQ-011 tx  output  1  serial line, idle high.
REQ-012 busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-013 state  output  4  current FSM state: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.

Function
REQ-014 The FSM SHALL have exactly five states: IDLE, START, DATA, PARITY, STOP.
REQ-015 s_ready SHALL equal 1 only in IDLE; a handshake occurs on a rising edge where s_valid and s_ready are both 1.
REQ-016 On a handshake, the block SHALL latch s_data, cfg_parity_en, cfg_parity_type, the decoded stop count and the effective divider, and SHALL enter START on the next cycle.
REQ-017 Configuration input changes while busy SHALL NOT affect the frame in progress.
REQ-018 tx SHALL be driven from a register: 1 in IDLE, 0 in START, the current data bit in DATA, the parity bit in PARITY, 1 in STOP.
REQ-019 Each bit SHALL last exactly D clocks, where D is the latched effective divider.
REQ-020 A bit counter SHALL step the DATA state through bits 0..7, LSB first, 8 bits total.
REQ-021 After data bit 7, the FSM SHALL go to PARITY if parity is enabled, otherwise to STOP.
REQ-022 The parity bit SHALL be the XOR of the 8 data bits for even parity, and its inverse for odd parity.
REQ-023 STOP SHALL last N*D clocks (N = 1 or 2), after which the FSM returns to IDLE.
REQ-024 The frame length from the first START cycle to the last STOP cycle SHALL be D*(1+8+P+N) clocks, with P = parity_en.
REQ-025 After STOP the block SHALL spend at least one cycle in IDLE (tx=1, s_ready=1) before the next START, so back-to-back frames are separated by exactly one idle clock when s_valid is held high.
REQ-026 s_valid asserted while busy SHALL be ignored, with no data loss; the upstream holds s_data until the handshake.
REQ-027 The divider counter SHALL count 0..D-1 with no overflow or wrap artefacts for D = 2^CLK_DIV_WIDTH-1.

Reset
REQ-028 While rst=1, on each rising clk the block SHALL set: state=IDLE, tx=1, s_ready=1, busy=0, and all counters and latched data to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame; tx SHALL be 1 from the first cycle after the reset edge, and no partial bits follow.
REQ-030 A handshake SHALL NOT occur in any cycle where rst=1.

Verification
REQ-031 Basic frame: D=4, parity off, N=1, byte 0xA5 -> tx samples start 0, then 1,0,1,0,0,1,0,1, then stop 1; each bit 4 clocks; 40 clocks total; s_ready returns high after it.
REQ-032 Parity and stop bits: D=2, even parity, N=2, byte 0x07 -> parity bit 1, two stop bits, 24 clocks; repeat with odd parity -> parity bit 0.
REQ-033 Back-to-back frames: s_valid held high with bytes 0x55 then 0xFF, D=1, parity off, N=1 -> frames of 10 clocks each, separated by exactly one tx=1 idle clock, with no byte lost or duplicated.
REQ-034 Config change mid-frame: start a frame with D=8 and parity off, then set cfg_clk_div=3 and cfg_parity_en=1 during DATA -> current frame stays 80 clocks with no parity; the next frame uses D=3 with parity.
REQ-035 Reset mid-frame: assert rst for 1 cycle during DATA bit 3 -> next cycle state=IDLE, tx=1, s_ready=1, busy=0; a new byte 0x3C afterwards is transmitted correctly.
REQ-036 Divider edge cases: cfg_clk_div=0 -> 1-clock bits; cfg_num_stop_bits=3 -> 2 stop bits; cfg_num_stop_bits=0 -> 1 stop bit.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Byte-wide UART transmitter. Accepts one byte per valid/ready handshake
//   and serialises it as: start bit (0), 8 data bits LSB first, an optional
//   parity bit, then one or two stop bits (1). Every bit lasts D clocks,
//   where D is the divider captured at the handshake (0 is treated as 1).
//   Framing options are captured together with the byte, so the upstream
//   may change cfg_* at any time without disturbing a frame in flight.
//
// Ports
//   clk               : sole clock, rising edge
//   rst               : synchronous active-high reset
//   s_data[7:0]       : byte to transmit
//   s_valid           : s_data valid
//   s_ready           : high only in IDLE; handshake when s_valid & s_ready
//   cfg_parity_en     : 1 = append parity bit
//   cfg_parity_type   : 0 = even, 1 = odd
//   cfg_num_stop_bits : 0/1 -> one stop bit, 2/3 -> two stop bits
//   cfg_clk_div       : clocks per bit (0 behaves as 1)
//   tx                : registered serial output, idles high
//   busy              : high in any state other than IDLE
//   state[3:0]        : IDLE=0, START=1, DATA=2, PARITY=3, STOP=4
module uart_tx_serializer #(
  parameter int CLK_DIV_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     cfg_parity_en,
  input  logic                     cfg_parity_type,
  input  logic [1:0]               cfg_num_stop_bits,
  input  logic [CLK_DIV_WIDTH-1:0] cfg_clk_div,
  output logic                     tx,
  output logic                     busy,
  output logic [3:0]               state
);

  localparam int DATA_W = 8;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_START  = 4'd1;
  localparam logic [3:0] ST_DATA   = 4'd2;
  localparam logic [3:0] ST_PARITY = 4'd3;
  localparam logic [3:0] ST_STOP   = 4'd4;

  localparam logic [CLK_DIV_WIDTH-1:0] DIV_ONE = {{(CLK_DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2:0]               LAST_BIT = 3'd7;

  // Even parity is the XOR of all data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  function automatic logic [CLK_DIV_WIDTH-1:0] eff_div(input logic [CLK_DIV_WIDTH-1:0] d);
    return (d == '0) ? DIV_ONE : d;
  endfunction

  // Only the upper bit of the stop-bit field matters: 2 and 3 mean two bits.
  function automatic logic two_stop(input logic [1:0] n);
    return n[1];
  endfunction

  logic [DATA_W-1:0]        shreg;     // data bits, current bit kept in [0]
  logic                     par_en_q;
  logic                     par_bit_q; // parity computed once at handshake
  logic                     two_stop_q;
  logic [CLK_DIV_WIDTH-1:0] div_q;     // latched effective divider, >= 1
  logic [CLK_DIV_WIDTH-1:0] div_cnt;   // 0 .. div_q-1 within a bit period
  logic [2:0]               bit_cnt;
  logic                     stop_cnt;  // which stop bit is being sent
  logic                     tx_q;
  logic                     bit_end;

  // div_q is never 0, so div_q-1 cannot underflow and div_cnt never reaches
  // the all-ones wrap point even for the largest divider.
  assign bit_end = (div_cnt == (div_q - DIV_ONE));

  assign s_ready = (state == ST_IDLE);
  assign busy    = (state != ST_IDLE);
  assign tx      = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx_q       <= 1'b1;
      shreg      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      div_q      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_valid) begin
            shreg      <= s_data;
            par_en_q   <= cfg_parity_en;
            par_bit_q  <= parity_bit(s_data, cfg_parity_type);
            two_stop_q <= two_stop(cfg_num_stop_bits);
            div_q      <= eff_div(cfg_clk_div);
            div_cnt    <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            state      <= ST_START;
            tx_q       <= 1'b0;
          end
        end

        ST_START: begin
          if (bit_end) begin
            div_cnt <= '0;
            state   <= ST_DATA;
            tx_q    <= shreg[0];
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              if (par_en_q) begin
                state <= ST_PARITY;
                tx_q  <= par_bit_q;
              end else begin
                state <= ST_STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_q    <= shreg[1];
              shreg   <= shreg >> 1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            div_cnt <= '0;
            state   <= ST_STOP;
            tx_q    <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (two_stop_q && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              state <= ST_IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end

        default: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  localparam int CDW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     s_data = 8'h00;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic           cfg_parity_en = 1'b0;
  logic           cfg_parity_type = 1'b0;
  logic [1:0]     cfg_num_stop_bits = 2'd0;
  logic [CDW-1:0] cfg_clk_div = '0;
  logic           tx;
  logic           busy;
  logic [3:0]     state;

  int passed = 0;
  int total  = 0;

  logic cap[$];
  logic exp[$];

  uart_tx_serializer #(.CLK_DIV_WIDTH(CDW)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_type(cfg_parity_type),
    .cfg_num_stop_bits(cfg_num_stop_bits), .cfg_clk_div(cfg_clk_div),
    .tx(tx), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  // Reference: list the frame's bits from the line rules, each held div clocks.
  task automatic model_frame(input logic [7:0] d, input int div, input bit pe,
                             input bit pt, input int ns);
    int dd = (div == 0) ? 1 : div;
    int nn = (ns >= 2) ? 2 : 1;
    bit b[$];
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (pe) b.push_back((^d) ^ pt);
    for (int i = 0; i < nn; i++) b.push_back(1'b1);
    foreach (b[j]) for (int k = 0; k < dd; k++) exp.push_back(b[j]);
  endtask

  task automatic set_cfg(input int div, input bit pe, input bit pt, input int ns);
    cfg_clk_div       = div[CDW-1:0];
    cfg_parity_en     = pe;
    cfg_parity_type   = pt;
    cfg_num_stop_bits = ns[1:0];
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    s_data  = d;
    s_valid = 1'b1;
  endtask

  task automatic capture(input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap.push_back(tx);
      if (i == drop_at) s_valid = 1'b0;
    end
  endtask

  function automatic int first_diff();
    if (cap.size() != exp.size()) return 0;
    foreach (exp[i]) if (cap[i] !== exp[i]) return i;
    return -1;
  endfunction

  task automatic clear_q();
    cap.delete();
    exp.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 8'hAA;
    repeat (3) @(negedge clk);
    total++; if (state !== 4'd0) $display("FAIL reset_state: got %0d want 0", state); else passed++;
    total++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else passed++;
    total++; if (s_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", s_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    s_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    total++; if (state !== 4'd0) $display("FAIL reset_release_state: got %0d want 0", state); else passed++;
  endtask

  task automatic test_basic();
    int idx;
    int busy_bad = 0;
    clear_q();
    set_cfg(4, 0, 0, 1);
    model_frame(8'hA5, 4, 0, 0, 1);
    send(8'hA5);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cap.push_back(tx);
      if (busy !== 1'b1 || s_ready !== 1'b0) busy_bad++;
      if (i == 0) s_valid = 1'b0;
    end
    idx = first_diff();
    total++; if (idx >= 0) $display("FAIL basic_frame: cycle %0d tx=%b want %b", idx, cap[idx], exp[idx]); else passed++;
    total++; if (busy_bad != 0) $display("FAIL basic_busy: %0d cycles not busy, want 0", busy_bad); else passed++;
    @(negedge clk);
    total++; if (s_ready !== 1'b1 || tx !== 1'b1) $display("FAIL basic_after: ready=%b tx=%b want 1 1", s_ready, tx); else passed++;
  endtask

  task automatic test_parity();
    int idx;
    for (int pt = 0; pt < 2; pt++) begin
      clear_q();
      set_cfg(2, 1, pt[0], 2);
      model_frame(8'h07, 2, 1, pt[0], 2);
      exp.push_back(1'b1);
      send(8'h07);
      capture(25, 0);
      idx = first_diff();
      total++; if (idx >= 0) $display("FAIL parity_frame_%0d: cycle %0d tx=%b want %b", pt, idx, cap[idx], exp[idx]); else passed++;
      total++; if (cap[18] !== ~pt[0]) $display("FAIL parity_bit_%0d: got %b want %b", pt, cap[18], ~pt[0]); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    clear_q();
    set_cfg(1, 0, 0, 1);
    model_frame(8'h55, 1, 0, 0, 1);
    exp.push_back(1'b1);
    model_frame(8'hFF, 1, 0, 0, 1);
    repeat (4) exp.push_back(1'b1);
    send(8'h55);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      cap.push_back(tx);
      if (i == 0) s_data = 8'hFF;
      if (i == 11) s_valid = 1'b0;
    end
    idx = first_diff();
    total++; if (idx >= 0) $display("FAIL back_to_back: cycle %0d tx=%b want %b", idx, cap[idx], exp[idx]); else passed++;
  endtask

  task automatic test_cfg_change();
    int idx;
    clear_q();
    set_cfg(8, 0, 0, 1);
    model_frame(8'hC3, 8, 0, 0, 1);
    exp.push_back(1'b1);
    send(8'hC3);
    for (int i = 0; i < 81; i++) begin
      @(negedge clk);
      cap.push_back(tx);
      if (i == 0) s_valid = 1'b0;
      if (i == 20) set_cfg(3, 1, 0, 1);
    end
    idx = first_diff();
    total++; if (idx >= 0) $display("FAIL cfg_hold_frame: cycle %0d tx=%b want %b", idx, cap[idx], exp[idx]); else passed++;
    clear_q();
    model_frame(8'h81, 3, 1, 0, 1);
    exp.push_back(1'b1);
    send(8'h81);
    capture(34, 0);
    idx = first_diff();
    total++; if (idx >= 0) $display("FAIL cfg_next_frame: cycle %0d tx=%b want %b", idx, cap[idx], exp[idx]); else passed++;
  endtask

  task automatic test_reset_midframe();
    int idx;
    clear_q();
    set_cfg(4, 0, 0, 1);
    send(8'h96);
    capture(18, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (state !== 4'd0) $display("FAIL midrst_state: got %0d want 0", state); else passed++;
    total++; if (tx !== 1'b1) $display("FAIL midrst_tx: got %b want 1", tx); else passed++;
    total++; if (s_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", s_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
    clear_q();
    repeat (6) exp.push_back(1'b1);
    capture(6, -1);
    idx = first_diff();
    total++; if (idx >= 0) $display("FAIL midrst_idle: cycle %0d tx=%b want %b", idx, cap[idx], exp[idx]); else passed++;
    clear_q();
    model_frame(8'h3C, 4, 0, 0, 1);
    exp.push_back(1'b1);
    send(8'h3C);
    capture(41, 0);
    idx = first_diff();
    total++; if (idx >= 0) $display("FAIL midrst_next: cycle %0d tx=%b want %b", idx, cap[idx], exp[idx]); else passed++;
  endtask

  task automatic test_edges();
    int idx;
    int divs[3]  = '{0, 2, 15};
    int pes[3]   = '{0, 1, 1};
    int stops[3] = '{3, 0, 2};
    logic [7:0] dat[3] = '{8'h9E, 8'h41, 8'hE7};
    for (int t = 0; t < 3; t++) begin
      clear_q();
      set_cfg(divs[t], pes[t][0], 1'b1, stops[t]);
      model_frame(dat[t], divs[t], pes[t][0], 1'b1, stops[t]);
      exp.push_back(1'b1);
      send(dat[t]);
      capture(exp.size(), 0);
      idx = first_diff();
      total++; if (idx >= 0) $display("FAIL edge_%0d: cycle %0d tx=%b want %b", t, idx, cap[idx], exp[idx]); else passed++;
    end
  endtask

  task automatic test_random();
    int idx;
    int div, ns;
    bit pe, pt;
    logic [7:0] d;
    for (int t = 0; t < 20; t++) begin
      clear_q();
      div = $urandom_range(0, 6);
      ns  = $urandom_range(0, 3);
      pe  = 1'($urandom_range(0, 1));
      pt  = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      set_cfg(div, pe, pt, ns);
      model_frame(d, div, pe, pt, ns);
      exp.push_back(1'b1);
      send(d);
      capture(exp.size(), 0);
      idx = first_diff();
      total++; if (idx >= 0) $display("FAIL random_%0d d=%h div=%0d pe=%0d pt=%0d ns=%0d: cycle %0d tx=%b want %b",
                                       t, d, div, pe, pt, ns, idx, cap[idx], exp[idx]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_cfg_change();
    test_reset_midframe();
    test_edges();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
